wb_button_master: RTL and testbench

Wishbone pipelined-mode bus master that turns two push-buttons into single-beat write transactions. It sits between the board's left and right buttons and the LED indicator slave. Each button is synchronised and debounced. Each debounced press becomes one write: left to address 0, right to address 1. The block honours slave stall, waits for ack, and aborts on timeout.

---
 rtl/wb_button_master.sv | 167 ++++++++++++++++
 tb/tb_wb_button_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_button_master.sv
// Wishbone pipelined master: two debounced buttons become single-beat
// writes (left -> addr 0, right -> addr 1) with stall, ack and timeout.
// Ports: i_clk, i_reset_n (async, active-low), i_btn_left/right (raw),
//   Wishbone master o_cyc/o_stb/o_we/o_addr/o_data, i_stall/i_ack/i_data,
//   status o_busy (= o_cyc) and o_err (sticky timeout flag).
module wb_button_master #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_data,
    input  logic        i_stall,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_err
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    // Index 0 is the left button, index 1 the right one.
    logic [1:0]          raw;
    logic [1:0]          s1_q, s2_q;
    logic [1:0]          lvl_q, lvl_d, lvl_dly_q;
    logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [1:0]          pend_q, pend_d;
    logic [1:0]          rise, take;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                addr_q, addr_d;
    logic                err_q, err_d;
    logic [7:0]          seq_q, seq_d;
    logic [TW-1:0]       tmo_q, tmo_d;

    logic                unused_data;

    assign raw         = {i_btn_right, i_btn_left};
    assign unused_data = ^i_data;

    // Counter only advances while the synchronised input disagrees with
    // the debounced level; DEBOUNCE_CYCLES such samples in a row flip it.
    always_comb begin
        lvl_d  = lvl_q;
        dcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != lvl_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = lvl_q & ~lvl_dly_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        err_d   = err_q;
        seq_d   = seq_q;
        tmo_d   = tmo_q;
        take    = '0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (|pend_q) begin
                    // Left wins; right stays pending for the next slot.
                    take    = pend_q[0] ? 2'b01 : 2'b10;
                    addr_d  = ~pend_q[0];
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end
            end
            REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d == TW'(TIMEOUT)) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (!i_stall) begin
                    state_d = WAIT_ACK;
                    stb_d   = 1'b0;
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + 1'b1;
                if (i_ack) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    seq_d   = seq_q + 1'b1;
                end else if (tmo_d == TW'(TIMEOUT)) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
        // A press arriving while the bit is still set is dropped.
        for (int i = 0; i < 2; i++) begin
            pend_d[i] = pend_q[i] ? ~take[i] : rise[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            dcnt_q    <= '0;
            pend_q    <= '0;
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            addr_q    <= 1'b0;
            err_q     <= 1'b0;
            seq_q     <= '0;
            tmo_q     <= '0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            dcnt_q    <= dcnt_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            seq_q     <= seq_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_cyc  = cyc_q;
    assign o_stb  = stb_q;
    assign o_we   = stb_q;
    assign o_addr = addr_q;
    assign o_data = {24'h0, seq_q};
    assign o_busy = cyc_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_wb_button_master.sv
// Self-checking bench for wb_button_master (DEBOUNCE_CYCLES=4, TIMEOUT=10):
// directed steps plus randomized presses/stalls/ack delays vs a simple model.
module tb_wb_button_master;

    localparam int D = 4;
    localparam int T = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        bl    = 1'b0;
    logic        br    = 1'b0;
    logic        stall = 1'b0;
    logic        ack   = 1'b0;
    logic [31:0] idata = 32'hdead_beef;
    logic        o_cyc, o_stb, o_we, o_addr, o_busy, o_err;
    logic [31:0] o_data;

    int   checks = 0;
    int   errors = 0;
    int   seq_m  = 0;
    logic err_m  = 1'b0;

    wb_button_master #(.DEBOUNCE_CYCLES(D), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_btn_left(bl), .i_btn_right(br),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
        .o_addr(o_addr), .o_data(o_data),
        .i_stall(stall), .i_ack(ack), .i_data(idata),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until o_stb rises and compare with the expected latency.
    task automatic wait_stb(input int lat, input string tag);
        int n = 0;
        while (o_stb !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, lat);
    endtask

    // Act as the slave: k stall cycles, then ack d cycles after acceptance.
    task automatic serve(input logic a, input int k, input int d);
        chk("req_we", {31'b0, o_we}, 1);
        chk("req_addr", {31'b0, o_addr}, {31'b0, a});
        chk("req_data", o_data, 32'(seq_m));
        chk("req_busy", {31'b0, o_busy}, 1);
        chk("req_err", {31'b0, o_err}, {31'b0, err_m});
        stall = (k > 0);
        for (int i = 0; i < k; i++) begin
            step();
            chk("stall_stb", {31'b0, o_stb}, 1);
            chk("stall_addr", {31'b0, o_addr}, {31'b0, a});
            chk("stall_data", o_data, 32'(seq_m));
        end
        stall = 1'b0;
        step();
        chk("accept_stb", {31'b0, o_stb}, 0);
        chk("accept_cyc", {31'b0, o_cyc}, 1);
        for (int i = 0; i < d; i++) begin
            step();
            chk("wait_cyc", {31'b0, o_cyc}, 1);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_cyc", {31'b0, o_cyc}, 0);
        chk("ack_busy", {31'b0, o_busy}, 0);
        seq_m = (seq_m + 1) % 256;
    endtask

    task automatic release_all();
        bl = 1'b0;
        br = 1'b0;
        for (int i = 0; i < D + 5; i++) begin
            step();
            chk("idle_cyc", {31'b0, o_cyc}, 0);
        end
    endtask

    initial begin
        int n;
        #12;
        chk("rst_cyc", {31'b0, o_cyc}, 0);
        chk("rst_stb", {31'b0, o_stb}, 0);
        chk("rst_data", o_data, 0);
        chk("rst_err", {31'b0, o_err}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Left press, no stall, ack next cycle.
        bl = 1'b1;
        wait_stb(D + 4, "lat_left");
        serve(1'b0, 0, 0);
        release_all();

        // Right press gives next seq.
        br = 1'b1;
        wait_stb(D + 4, "lat_right");
        serve(1'b1, 0, 0);
        release_all();

        // Right press with 5 stall cycles.
        br = 1'b1;
        wait_stb(D + 4, "lat_stall");
        serve(1'b1, 5, 0);
        release_all();

        // Both rise together: left then right, idle gap between.
        bl = 1'b1;
        br = 1'b1;
        wait_stb(D + 4, "lat_both");
        serve(1'b0, 0, 0);
        wait_stb(1, "both_second");
        serve(1'b1, 0, 1);
        chk("both_seq", o_data, 32'(seq_m));
        release_all();

        // Short bounces never create a transaction.
        for (int p = 0; p < 6; p++) begin
            bl = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            bl = 1'b0;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                step();
                chk("bounce_cyc", {31'b0, o_cyc}, 0);
            end
        end
        for (int i = 0; i < D + 4; i++) begin
            step();
            chk("bounce_tail", {31'b0, o_cyc}, 0);
        end
        bl = 1'b1;
        wait_stb(D + 4, "lat_after_bounce");
        serve(1'b0, 0, 0);
        release_all();

        // Randomized presses, stalls and ack delays.
        for (int r = 0; r < 10; r++) begin
            int sel;
            sel = $urandom_range(0, 2);
            bl = (sel != 1);
            br = (sel != 0);
            wait_stb(D + 4, "lat_rand");
            serve(sel == 1, $urandom_range(0, 5), $urandom_range(0, 2));
            if (sel == 2) begin
                wait_stb(1, "rand_second");
                serve(1'b1, $urandom_range(0, 5), $urandom_range(0, 2));
            end
            release_all();
        end

        // Slave never acks: abort after T cycles, sticky error.
        bl = 1'b1;
        wait_stb(D + 4, "lat_tmo");
        n = 0;
        while (o_cyc === 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("tmo_len", n, T);
        chk("tmo_err", {31'b0, o_err}, 1);
        chk("tmo_stb", {31'b0, o_stb}, 0);
        err_m = 1'b1;
        release_all();
        chk("tmo_err_sticky", {31'b0, o_err}, 1);
        br = 1'b1;
        wait_stb(D + 4, "lat_post_tmo");
        serve(1'b1, 0, 0);
        release_all();

        // Reset asserted in WAIT_ACK.
        bl = 1'b1;
        wait_stb(D + 4, "lat_rst");
        step();
        chk("rst_pre_cyc", {31'b0, o_cyc}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'b0, o_cyc}, 0);
        chk("arst_busy", {31'b0, o_busy}, 0);
        chk("arst_err", {31'b0, o_err}, 0);
        chk("arst_data", o_data, 0);
        bl = 1'b0;
        seq_m = 0;
        err_m = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < D + 6; i++) begin
            step();
            chk("post_rst_idle", {31'b0, o_cyc}, 0);
        end
        bl = 1'b1;
        wait_stb(D + 4, "lat_fresh");
        serve(1'b0, 0, 0);
        release_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
